// File: rtl/cnn_pkg.sv
// Shared widths, FSM states and output saturation for the CNN state-update block.
package cnn_pkg;

  localparam int WIDTH  = 9;
  localparam int DATA_W = 2 * WIDTH;
  localparam int COEF_W = 9;
  localparam int FRAC   = 4;
  localparam int TAPS   = 9;
  localparam int HSHIFT = 2;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 4;
  localparam int PROD_W = COEF_W + DATA_W;
  localparam int DIFF_W = ACC_W + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, OUTPUT} state_e;

  localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [DIFF_W-1:0] v);
    logic signed [DIFF_W-1:0] hi, lo;
    hi = DIFF_W'(DATA_MAX);
    lo = DIFF_W'(DATA_MIN);
    if (v > hi)      sat = DATA_MAX;
    else if (v < lo) sat = DATA_MIN;
    else             sat = v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/cnn_tap_mac.sv
// One template tap: (a*y)>>>FRAC + (b*u)>>>FRAC at full product precision.
module cnn_tap_mac
  import cnn_pkg::*;
(
  input  logic signed [COEF_W-1:0] a_coef_i,
  input  logic signed [DATA_W-1:0] y_i,
  input  logic signed [COEF_W-1:0] b_coef_i,
  input  logic signed [DATA_W-1:0] u_i,
  output logic signed [ACC_W-1:0]  contrib_o
);

  logic signed [PROD_W-1:0] prod_a, prod_b, sh_a, sh_b;

  // Operands are widened first so the multiply is done at PROD_W.
  assign prod_a = PROD_W'(a_coef_i) * PROD_W'(y_i);
  assign prod_b = PROD_W'(b_coef_i) * PROD_W'(u_i);
  assign sh_a   = prod_a >>> FRAC;
  assign sh_b   = prod_b >>> FRAC;

  assign contrib_o = ACC_W'(sh_a) + ACC_W'(sh_b);

endmodule

// File: rtl/cnn_state_update.sv
// Forward-Euler CNN state step: x' = x + ((sum(A*y)+sum(B*u)+I-x) >>> HSHIFT),
// taps streamed serially, result saturated and held on a valid/ready output.
module cnn_state_update
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] bias,
  output logic              busy,
  input  logic              tap_valid,
  output logic              tap_ready,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] u_in,
  input  logic [COEF_W-1:0] a_coef,
  input  logic [COEF_W-1:0] b_coef,
  output logic [DATA_W-1:0] x_out,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] x_q, x_d;
  logic signed [DATA_W-1:0] bias_q, bias_d;
  logic signed [DATA_W-1:0] xout_q, xout_d;
  logic                     ovld_q, ovld_d;

  logic signed [ACC_W-1:0]  contrib;
  logic signed [DIFF_W-1:0] diff, sum;

  cnn_tap_mac u_mac (
    .a_coef_i  ($signed(a_coef)),
    .y_i       ($signed(y_in)),
    .b_coef_i  ($signed(b_coef)),
    .u_i       ($signed(u_in)),
    .contrib_o (contrib)
  );

  // Wide enough that neither the difference nor the step can wrap before saturation.
  assign diff = DIFF_W'(acc_q) + DIFF_W'(bias_q) - DIFF_W'(x_q);
  assign sum  = DIFF_W'(x_q) + (diff >>> HSHIFT);

  assign busy      = (state_q != IDLE);
  assign tap_ready = (state_q == ACCUM);
  assign x_out     = xout_q;
  assign out_valid = ovld_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    bias_d  = bias_q;
    xout_d  = xout_q;
    ovld_d  = ovld_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          x_d     = $signed(x_in);
          bias_d  = $signed(bias);
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (tap_valid) begin
          acc_d = acc_q + contrib;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(TAPS - 1)) state_d = UPDATE;
        end
      end
      UPDATE: begin
        xout_d  = sat(sum);
        ovld_d  = 1'b1;
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      bias_q  <= '0;
      xout_q  <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      bias_q  <= bias_d;
      xout_q  <= xout_d;
      ovld_q  <= ovld_d;
    end
  end

endmodule

// File: tb/tb_cnn_state_update.sv
// Directed vector bench for cnn_state_update: table of full updates plus
// reset, backpressure and ignored-start sequences.
module tb_cnn_state_update;

  logic        clk = 1'b0;
  logic        rst_n, start, tap_valid, out_ready;
  logic [17:0] x_in, bias, y_in, u_in;
  logic [8:0]  a_coef, b_coef;
  logic        busy, tap_ready, out_valid;
  logic [17:0] x_out;

  int nvec = 0;
  int nerr = 0;

  cnn_state_update dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_in      (x_in),
    .bias      (bias),
    .busy      (busy),
    .tap_valid (tap_valid),
    .tap_ready (tap_ready),
    .y_in      (y_in),
    .u_in      (u_in),
    .a_coef    (a_coef),
    .b_coef    (b_coef),
    .x_out     (x_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int x; int bias; int a; int y; int b; int u; int nz; int exp;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int xo();
    return int'($signed(x_out));
  endfunction

  task automatic set_tap(input int a, input int y, input int b, input int u);
    a_coef = 9'(a);
    y_in   = 18'(y);
    b_coef = 9'(b);
    u_in   = 18'(u);
  endtask

  // Called in an IDLE cycle; start is raised in this cycle (cycle 0).
  task automatic run_vec(input int idx, input vec_t v);
    start = 1'b1;
    x_in  = 18'(v.x);
    bias  = 18'(v.bias);
    step();
    start = 1'b0;
    x_in  = 18'h15555;
    bias  = 18'h2aaaa;
    chk($sformatf("v%0d tap_ready_c1", idx), int'(tap_ready), 1);
    for (int k = 0; k < 9; k++) begin
      tap_valid = 1'b1;
      if (k < v.nz) set_tap(v.a, v.y, v.b, v.u);
      else          set_tap(0, 0, 0, 0);
      step();
    end
    tap_valid = 1'b0;
    set_tap(0, 0, 0, 0);
    chk($sformatf("v%0d out_valid_c10", idx), int'(out_valid), 0);
    step();
    chk($sformatf("v%0d out_valid_c11", idx), int'(out_valid), 1);
    chk($sformatf("v%0d x_out", idx), xo(), v.exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk($sformatf("v%0d out_valid_drop", idx), int'(out_valid), 0);
    chk($sformatf("v%0d busy_idle", idx), int'(busy), 0);
  endtask

  vec_t vecs[9];

  initial begin
    int accepted, extra, cyc, seen, bad;
    //          x        bias  a    y        b    u    nz  exp
    vecs[0] = '{100,     0,    0,   0,       0,   0,   0,  75};
    vecs[1] = '{0,       8,    16,  40,      0,   0,   1,  12};
    vecs[2] = '{1,       0,    0,   0,       0,   0,   0,  0};
    vecs[3] = '{131000,  0,    255, 131071,  0,   0,   9,  131071};
    vecs[4] = '{-131000, 0,    255, -131072, 0,   0,   9,  -131072};
    vecs[5] = '{0,       0,    -1,  1,       -1,  1,   9,  -5};
    vecs[6] = '{200,     -50,  -16, 40,      32,  -3,  3,  103};
    vecs[7] = '{-400,    100,  0,   0,       48,  100, 2,  -125};
    vecs[8] = '{-7,      0,    0,   0,       0,   0,   0,  -6};

    rst_n = 1'b0; start = 1'b0; tap_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; bias = '0;
    set_tap(0, 0, 0, 0);
    step();
    step();
    chk("rst x_out", xo(), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst tap_ready", int'(tap_ready), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset mid-ACCUM discards the partial result.
    start = 1'b1; x_in = 18'd100; bias = 18'd0;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tap_valid = 1'b1;
      set_tap(16, 1000, 0, 0);
      step();
    end
    rst_n = 1'b0;
    step();
    step();
    chk("midrst x_out", xo(), 0);
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst tap_ready", int'(tap_ready), 0);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (out_valid || busy) bad++;
    end
    chk("midrst no_activity", bad, 0);
    tap_valid = 1'b0;
    set_tap(0, 0, 0, 0);

    // Backpressure: toggling tap_valid, a start mid-ACCUM, out_ready held low.
    start = 1'b1; x_in = 18'd0; bias = 18'd0;
    step();
    start = 1'b0;
    accepted = 0; cyc = 0;
    while (accepted < 9 && cyc < 40) begin
      tap_valid = (cyc % 2 == 0);
      set_tap(16, 10, 0, 0);
      start = (cyc == 5);
      x_in  = (cyc == 5) ? 18'd5000 : 18'd0;
      if (tap_valid && tap_ready) accepted++;
      step();
      cyc++;
    end
    start = 1'b0;
    chk("bp accepted", accepted, 9);
    extra = 0; seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (out_valid) seen = 1;
      else begin
        tap_valid = ~tap_valid;
        if (tap_valid && tap_ready) extra++;
        step();
      end
    end
    tap_valid = 1'b0;
    chk("bp out_valid_seen", seen, 1);
    chk("bp extra_beats", extra, 0);
    chk("bp x_out", xo(), 22);
    for (int k = 0; k < 5; k++) begin
      start = 1'b1;
      x_in  = 18'd777;
      step();
      chk($sformatf("bp hold%0d out_valid", k), int'(out_valid), 1);
      chk($sformatf("bp hold%0d x_out", k), xo(), 22);
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp drop out_valid", int'(out_valid), 0);
    chk("bp drop busy", int'(busy), 0);
    chk("bp retain x_out", xo(), 22);
    step();
    chk("bp no_queued_start", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
